// File: rtl/lorenz_pkg.sv
// ============================================================================
// Module : lorenz_pkg
// Brief  : Shared constants, Q7.25 coefficient presets and FSM states for the
//          Lorenz stepper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lorenz_pkg;

    localparam int DEF_W    = 32;
    localparam int DEF_FRAC = 25;

    // Q7.25 presets for the classic attractor (sigma=10, rho=28, beta=8/3)
    localparam logic [DEF_W-1:0] ONE      = 32'h0200_0000;
    localparam logic [DEF_W-1:0] SIGMA_10 = 32'h1400_0000;
    localparam logic [DEF_W-1:0] RHO_28   = 32'h3800_0000;
    localparam logic [DEF_W-1:0] BETA_8_3 = 32'h0555_5555;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_M0   = 3'd1,
        ST_M1   = 3'd2,
        ST_M2   = 3'd3,
        ST_M3   = 3'd4,
        ST_UPD  = 3'd5,
        ST_HOLD = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/lorenz_stepper_if.sv
// ============================================================================
// Module : lorenz_stepper_if
// Brief  : Command, coefficient and sample-stream bundle of the Lorenz stepper.
//          master = the stepper, slave = the controller/consumer side.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lorenz_stepper_if #(
    parameter int W     = 32,
    parameter int CNT_W = 16
);
    logic             load;
    logic [W-1:0]     x0;
    logic [W-1:0]     y0;
    logic [W-1:0]     z0;
    logic [W-1:0]     sigma;
    logic [W-1:0]     rho;
    logic [W-1:0]     beta;
    logic             run;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     x;
    logic [W-1:0]     y;
    logic [W-1:0]     z;
    logic [CNT_W-1:0] step_cnt;
    logic             busy;

    modport master (
        input  load, x0, y0, z0, sigma, rho, beta, run, out_ready,
        output out_valid, x, y, z, step_cnt, busy
    );

    modport slave (
        output load, x0, y0, z0, sigma, rho, beta, run, out_ready,
        input  out_valid, x, y, z, step_cnt, busy
    );

endinterface

`default_nettype wire

// File: rtl/lorenz_fxmul.sv
// ============================================================================
// Module : lorenz_fxmul
// Brief  : Combinational signed fixed-point multiplier; full product shifted
//          right by FRAC (floor) and truncated to OUTW bits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lorenz_fxmul #(
    parameter int OPW  = 33,
    parameter int FRAC = 25,
    parameter int OUTW = 35
) (
    input  logic signed [OPW-1:0]  a,
    input  logic signed [OPW-1:0]  b,
    output logic signed [OUTW-1:0] p
);

    logic signed [2*OPW-1:0] w_full;
    logic signed [2*OPW-1:0] w_shift;
    logic                    w_unused;

    assign w_full   = a * b;
    assign w_shift  = w_full >>> FRAC;
    assign p        = w_shift[OUTW-1:0];
    // The discarded high bits only matter for results far outside the accumulator range.
    assign w_unused = ^w_shift;

endmodule

`default_nettype wire

// File: rtl/lorenz_stepper.sv
// ============================================================================
// Module : lorenz_stepper
// Brief  : Forward-Euler Lorenz integrator with one time-shared multiplier,
//          loadable state, step counter and valid/ready sample output.
// Build  : define LORENZ_SAT_EN to saturate committed x/y/z instead of wrapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lorenz_stepper
    import lorenz_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int FRAC     = DEF_FRAC,
    parameter int DT_SHIFT = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    lorenz_stepper_if.master bus
);

    localparam int OPW = W + 1;
    localparam int SW  = W + 3;

    state_t               r_state;
    logic signed [W-1:0]  r_x;
    logic signed [W-1:0]  r_y;
    logic signed [W-1:0]  r_z;
    logic signed [W-1:0]  r_sigma;
    logic signed [W-1:0]  r_rho;
    logic signed [W-1:0]  r_beta;
    logic signed [SW-1:0] r_p0;
    logic signed [SW-1:0] r_p1;
    logic signed [SW-1:0] r_p2;
    logic signed [SW-1:0] r_p3;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_valid;
    logic                 r_busy;

    logic signed [OPW-1:0] w_xe;
    logic signed [OPW-1:0] w_ye;
    logic signed [OPW-1:0] w_ze;
    logic signed [OPW-1:0] w_diff_yx;
    logic signed [OPW-1:0] w_diff_rz;
    logic signed [OPW-1:0] w_xs;
    logic signed [OPW-1:0] w_ys;
    logic signed [OPW-1:0] w_zs;
    logic signed [OPW-1:0] w_ma;
    logic signed [OPW-1:0] w_mb;
    logic signed [SW-1:0]  w_prod;
    logic signed [SW-1:0]  w_x_sum;
    logic signed [SW-1:0]  w_y_sum;
    logic signed [SW-1:0]  w_z_sum;
    logic signed [W-1:0]   w_x_new;
    logic signed [W-1:0]   w_y_new;
    logic signed [W-1:0]   w_z_new;
    logic                  w_unused;

    assign w_xe      = OPW'(r_x);
    assign w_ye      = OPW'(r_y);
    assign w_ze      = OPW'(r_z);
    assign w_diff_yx = w_ye - w_xe;
    assign w_diff_rz = OPW'(r_rho) - w_ze;
    assign w_xs      = w_xe >>> DT_SHIFT;
    assign w_ys      = w_ye >>> DT_SHIFT;
    assign w_zs      = w_ze >>> DT_SHIFT;

    always_comb begin
        w_ma = '0;
        w_mb = '0;
        case (r_state)
            ST_M0: begin
                w_ma = OPW'(r_sigma);
                w_mb = w_diff_yx >>> DT_SHIFT;
            end
            ST_M1: begin
                w_ma = w_xs;
                w_mb = w_diff_rz;
            end
            ST_M2: begin
                w_ma = w_xs;
                w_mb = w_ye;
            end
            ST_M3: begin
                w_ma = w_zs;
                w_mb = OPW'(r_beta);
            end
            default: begin
                w_ma = '0;
                w_mb = '0;
            end
        endcase
    end

    lorenz_fxmul #(
        .OPW  (OPW),
        .FRAC (FRAC),
        .OUTW (SW)
    ) u_fxmul (
        .a (w_ma),
        .b (w_mb),
        .p (w_prod)
    );

    assign w_x_sum = SW'(r_x) + r_p0;
    assign w_y_sum = SW'(r_y) + r_p1 - SW'(w_ys);
    assign w_z_sum = SW'(r_z) + r_p2 - r_p3;

`ifdef LORENZ_SAT_EN
    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    // In range exactly when every bit above the W-bit sign agrees with it.
    function automatic logic [W-1:0] fit_w(input logic [SW-1:0] v);
        logic [W-1:0] res;
        if ((v[SW-1:W-1] == '0) || (v[SW-1:W-1] == '1)) begin
            res = v[W-1:0];
        end else if (v[SW-1]) begin
            res = SAT_MIN;
        end else begin
            res = SAT_MAX;
        end
        return res;
    endfunction

    assign w_x_new = fit_w(w_x_sum);
    assign w_y_new = fit_w(w_y_sum);
    assign w_z_new = fit_w(w_z_sum);
`else
    assign w_x_new = w_x_sum[W-1:0];
    assign w_y_new = w_y_sum[W-1:0];
    assign w_z_new = w_z_sum[W-1:0];
`endif

    assign w_unused = ^{w_x_sum, w_y_sum, w_z_sum};

    // Coefficients are latched on the edge into M0 so every product of a step sees one set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_sigma <= '0;
            r_rho   <= '0;
            r_beta  <= '0;
            r_p0    <= '0;
            r_p1    <= '0;
            r_p2    <= '0;
            r_p3    <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else if (bus.load) begin
            r_state <= ST_IDLE;
            r_x     <= bus.x0;
            r_y     <= bus.y0;
            r_z     <= bus.z0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.run) begin
                        r_state <= ST_M0;
                        r_busy  <= 1'b1;
                        r_sigma <= bus.sigma;
                        r_rho   <= bus.rho;
                        r_beta  <= bus.beta;
                    end
                end
                ST_M0: begin
                    r_p0    <= w_prod;
                    r_state <= ST_M1;
                end
                ST_M1: begin
                    r_p1    <= w_prod;
                    r_state <= ST_M2;
                end
                ST_M2: begin
                    r_p2    <= w_prod;
                    r_state <= ST_M3;
                end
                ST_M3: begin
                    r_p3    <= w_prod;
                    r_state <= ST_UPD;
                end
                ST_UPD: begin
                    r_x     <= w_x_new;
                    r_y     <= w_y_new;
                    r_z     <= w_z_new;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    r_valid <= 1'b1;
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        r_valid <= 1'b0;
                        if (bus.run) begin
                            r_state <= ST_M0;
                            r_sigma <= bus.sigma;
                            r_rho   <= bus.rho;
                            r_beta  <= bus.beta;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.x         = r_x;
    assign bus.y         = r_y;
    assign bus.z         = r_z;
    assign bus.step_cnt  = r_cnt;
    assign bus.out_valid = r_valid;
    assign bus.busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_lorenz_stepper.sv
// ============================================================================
// Module : tb_lorenz_stepper
// Brief  : Directed self-checking bench for lorenz_stepper (CNT_W=16 and CNT_W=4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lorenz_stepper;

    localparam logic [31:0] K_ONE   = 32'h0200_0000;
    localparam logic [31:0] K_SIGMA = 32'h1400_0000;
    localparam logic [31:0] K_RHO   = 32'h3800_0000;
    localparam logic [31:0] K_BETA  = 32'h0555_5555;
`ifdef LORENZ_SAT_EN
    localparam logic [31:0] K_OVF_Y = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] K_OVF_Y = 32'hA2D8_0000;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    lorenz_stepper_if #(.W(32), .CNT_W(16)) bus1 ();
    lorenz_stepper_if #(.W(32), .CNT_W(4))  bus2 ();

    lorenz_stepper #(.W(32), .FRAC(25), .DT_SHIFT(8), .CNT_W(16)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    lorenz_stepper #(.W(32), .FRAC(25), .DT_SHIFT(8), .CNT_W(4)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_valid(input bit sel, input string tag, output int cyc);
        cyc = 0;
        while (((sel ? bus2.out_valid : bus1.out_valid) !== 1'b1) && (cyc < 40)) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 64'(sel ? bus2.out_valid : bus1.out_valid), 64'd1);
    endtask

    // Reference Euler step with the default coefficients, dt = 2^-8, Q7.25.
    task automatic model_step(inout logic [31:0] mx, inout logic [31:0] my, inout logic [31:0] mz);
        logic signed [32:0] ex, ey, ez, d, xs, ys, zs, dr;
        logic signed [65:0] f0, f1, f2, f3;
        logic signed [34:0] p0, p1, p2, p3, sx, sy, sz;
        ex = $signed({mx[31], mx});
        ey = $signed({my[31], my});
        ez = $signed({mz[31], mz});
        d  = (ey - ex) >>> 8;
        xs = ex >>> 8;
        ys = ey >>> 8;
        zs = ez >>> 8;
        dr = $signed({K_RHO[31], K_RHO}) - ez;
        f0 = $signed({K_SIGMA[31], K_SIGMA}) * d;
        f1 = xs * dr;
        f2 = xs * ey;
        f3 = zs * $signed({K_BETA[31], K_BETA});
        p0 = 35'(f0 >>> 25);
        p1 = 35'(f1 >>> 25);
        p2 = 35'(f2 >>> 25);
        p3 = 35'(f3 >>> 25);
        sx = 35'(ex) + p0;
        sy = 35'(ey) + p1 - 35'(ys);
        sz = 35'(ez) + p2 - p3;
        mx = sx[31:0];
        my = sy[31:0];
        mz = sz[31:0];
    endtask

    initial begin
        int          cyc;
        logic        stable;
        logic        seen;
        logic [31:0] mx, my, mz;

        rst_n = 1'b0;
        bus1.load = 1'b0; bus1.run = 1'b0; bus1.out_ready = 1'b0;
        bus1.x0 = '0; bus1.y0 = '0; bus1.z0 = '0;
        bus1.sigma = K_SIGMA; bus1.rho = K_RHO; bus1.beta = K_BETA;
        bus2.load = 1'b0; bus2.run = 1'b0; bus2.out_ready = 1'b0;
        bus2.x0 = '0; bus2.y0 = '0; bus2.z0 = '0;
        bus2.sigma = K_SIGMA; bus2.rho = K_RHO; bus2.beta = K_BETA;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_x", bus1.x, 0);
        check("rst_y", bus1.y, 0);
        check("rst_z", bus1.z, 0);
        check("rst_cnt", bus1.step_cnt, 0);
        check("rst_valid", bus1.out_valid, 0);
        check("rst_busy", bus1.busy, 0);

        // load (0, 1.0, 0)
        bus1.x0 = '0; bus1.y0 = K_ONE; bus1.z0 = '0; bus1.load = 1'b1;
        @(negedge clk);
        bus1.load = 1'b0;
        check("load_y", bus1.y, K_ONE);
        check("load_busy", bus1.busy, 0);

        // single step with backpressure held off
        bus1.run = 1'b1;
        cyc = 0;
        while ((bus1.busy !== 1'b1) && (cyc < 10)) begin
            @(negedge clk);
            cyc++;
        end
        check("m0_reached", bus1.busy, 1);
        wait_valid(1'b0, "step1_valid", cyc);
        check("step1_latency", 64'(cyc), 64'd5);
        check("step1_x", bus1.x, 32'h0014_0000);
        check("step1_y", bus1.y, 32'h01FE_0000);
        check("step1_z", bus1.z, 32'h0000_0000);
        check("step1_cnt", bus1.step_cnt, 1);

        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ((bus1.out_valid !== 1'b1) || (bus1.x !== 32'h0014_0000) ||
                (bus1.y !== 32'h01FE_0000) || (bus1.z !== 32'h0) || (bus1.step_cnt !== 16'd1))
                stable = 1'b0;
        end
        check("bp_hold", stable, 1);

        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
        check("step2_start_valid", bus1.out_valid, 0);
        check("step2_start_busy", bus1.busy, 1);
        wait_valid(1'b0, "step2_valid", cyc);
        check("step2_x", bus1.x, 32'h0027_2400);
        check("step2_y", bus1.y, 32'h01FE_3200);
        check("step2_z", bus1.z, 32'h0000_13EC);
        check("step2_cnt", bus1.step_cnt, 2);

        // asynchronous reset in the middle of M2
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus1.run = 1'b0;
        check("m2_busy", bus1.busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_x", bus1.x, 0);
        check("arst_y", bus1.y, 0);
        check("arst_z", bus1.z, 0);
        check("arst_cnt", bus1.step_cnt, 0);
        check("arst_valid", bus1.out_valid, 0);
        check("arst_busy", bus1.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // load during M1 aborts the step
        bus1.x0 = '0; bus1.y0 = K_ONE; bus1.z0 = '0; bus1.load = 1'b1;
        @(negedge clk);
        bus1.load = 1'b0;
        bus1.run  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus1.load = 1'b1; bus1.x0 = K_ONE; bus1.y0 = '0; bus1.z0 = '0;
        bus1.run  = 1'b0;
        @(negedge clk);
        bus1.load = 1'b0;
        check("abort_x", bus1.x, K_ONE);
        check("abort_y", bus1.y, 0);
        check("abort_cnt", bus1.step_cnt, 0);
        check("abort_busy", bus1.busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus1.out_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        check("abort_no_valid", seen, 0);

        // overflow step, run dropped during the step
        bus1.x0 = 32'h7E00_0000; bus1.y0 = 32'h7800_0000; bus1.z0 = 32'h8800_0000;
        bus1.load = 1'b1;
        @(negedge clk);
        bus1.load = 1'b0;
        bus1.run  = 1'b1;
        @(negedge clk);
        bus1.run  = 1'b0;
        wait_valid(1'b0, "ovf_valid", cyc);
        check("ovf_x", bus1.x, 32'h7DC4_0000);
        check("ovf_y", bus1.y, K_OVF_Y);
        check("ovf_z", bus1.z, 32'hA6C8_0000);
        check("ovf_cnt", bus1.step_cnt, 1);
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
        check("ovf_idle_busy", bus1.busy, 0);
        check("ovf_idle_valid", bus1.out_valid, 0);

        // 4-bit counter wraps after 16 committed steps
        bus2.x0 = '0; bus2.y0 = K_ONE; bus2.z0 = '0; bus2.load = 1'b1;
        @(negedge clk);
        bus2.load = 1'b0;
        mx = '0; my = K_ONE; mz = '0;
        bus2.run = 1'b1;
        bus2.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_valid(1'b1, "wrap_valid", cyc);
            model_step(mx, my, mz);
            if (i == 0) check("wrap_cnt_first", bus2.step_cnt, 1);
            if (i == 15) bus2.run = 1'b0;
            @(negedge clk);
        end
        bus2.out_ready = 1'b0;
        check("wrap_cnt", bus2.step_cnt, 0);
        check("wrap_x", bus2.x, mx);
        check("wrap_y", bus2.y, my);
        check("wrap_z", bus2.z, mz);
        check("wrap_busy", bus2.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lorenz_stepper.md
Name: lorenz_stepper

Overview:
- Parametrised, handshaked successor to the free-running Lorenz attractor integrator.
- Forward-Euler update of (x,y,z) in signed fixed point with run-time coefficients (sigma, rho, beta), loadable initial state, step counter and valid/ready output backpressure.
- A single time-shared fixed-point multiplier is sequenced by an FSM.
- Feeds the display/scaling path, which consumes one state sample per accepted step.

Parameters:
- W, 32, total signed word width of x/y/z and coefficients.
- FRAC, 25, fractional bits (default Q7.25; 1.0 = 0x02000000).
- DT_SHIFT, 8, dt = 2^-DT_SHIFT, applied as arithmetic right shift.
- CNT_W, 16, step counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  pulse; captures x0/y0/z0 into state.
- x0, y0, z0  in  W each  initial state (QW.FRAC).
- sigma, rho, beta  in  W each  coefficients.
- run  in  1  level; 1 = keep stepping.
- out_valid  out  1  new state sample available.
- out_ready  in  1  consumer accepts sample.
- x, y, z  out  W each  current state.
- step_cnt  out  CNT_W  committed steps since last load/reset.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - x=y=z=0, step_cnt=0, out_valid=0, busy=0, FSM=IDLE.
  - Internal products and coefficient registers cleared.
- FSM states: IDLE, M0, M1, M2, M3, UPD, HOLD.
- IDLE:
  - load=1 → x/y/z←x0/y0/z0, step_cnt←0, stay IDLE.
  - else run=1 → M0.
- M0: registers sigma/rho/beta (coefficients are stable for the whole step), computes p0 = sigma*((y−x)>>>DT_SHIFT).
- M1: p1 = (x>>>DT_SHIFT)*(rho−z).
- M2: p2 = (x>>>DT_SHIFT)*y.
- M3: p3 = (z>>>DT_SHIFT)*beta.
- UPD commits, then → HOLD:
  - x←x+p0
  - y←y+p1−(y>>>DT_SHIFT)
  - z←z+p2−p3
  - step_cnt←step_cnt+1, wraps modulo 2^CNT_W
- HOLD:
  - out_valid=1; x/y/z stable.
  - Leaves on out_ready=1: to M0 if run=1, else IDLE. out_valid drops the next cycle unless M0 is reached and completes.
- Latency: 5 cycles from entering M0 to out_valid=1. Max throughput is 1 sample per 6 cycles with out_ready tied high.
- Arithmetic:
  - y−x and rho−z computed in W+1 bits, then shifted.
  - Multiplier: signed (W+1)×(W+1), full product >>> FRAC, truncation toward −inf.
  - Sums accumulated in W+3 bits, then reduced to W (see Optional Feature).
- Boundary conditions:
  - load in any non-IDLE state: aborts the step, loads state, step_cnt←0, out_valid←0, → IDLE. load has priority over run and out_ready.
  - run deasserted mid-step: the step completes and is presented; then → IDLE.
  - out_ready while out_valid=0: ignored.
  - rst_n mid-step: immediate reset values, no partial commit.

Optional Feature:
- Macro LORENZ_SAT_EN.
- Defined: each committed x/y/z saturates to [−2^(W−1), 2^(W−1)−1] (0x80000000 / 0x7FFFFFFF at default).
- Undefined: low W bits kept, two's-complement wrap.

Decomposition:
- Package lorenz_pkg: default W/FRAC constants, FSM state enum, Q-format constants (ONE, SIGMA_10, RHO_28, BETA_8_3 = 0x05555555).
- Sub-module lorenz_fxmul: parametrised signed fixed-point multiplier (operand width, FRAC); one instance, combinational, operands muxed by FSM state.

Test Plan:
- Reset: rst_n=0 mid-M2 → x=y=z=0, step_cnt=0, out_valid=0, busy=0 immediately.
- Single step, default coefficients:
  - Stimulus: load x0=0, y0=0x02000000, z0=0, run=1, out_ready=1.
  - Response: out_valid exactly 5 cycles after M0; x=0x00140000, y=0x01FE0000, z=0, step_cnt=1.
- Backpressure: out_ready=0 for 10 cycles after first out_valid → x/y/z and out_valid held; step_cnt stays 1; on out_ready=1 next step starts.
- Load abort: load asserted during M1 with x0=1.0 → x=0x02000000, step_cnt=0, FSM IDLE, no out_valid pulse.
- Overflow:
  - Stimulus: x0=63.0, y0=60.0, z0=−60.0, rho=28.
  - With LORENZ_SAT_EN: y=0x7FFFFFFF.
  - Without: y equals true sum mod 2^32 (negative).
- Counter wrap: CNT_W=4, 16 steps → step_cnt=0, dynamics unaffected.
